split_frame_length: RTL and testbench
=====================================

Name: split_frame_length

Overview:
- Inverse of connect_frame_length. Accepts a single AXI4-Stream of the form [frame length header]/[Ethernet frame].
- Strips the header beats onto a dedicated frame-length stream and forwards the Ethernet payload on a separate data stream with tkeep.
- Sits at the egress side of switch buffering, where downstream logic (ATS/shaper, MAC TX) needs the length ahead of, and independently from, the frame bytes.

Parameters:
- C_AXIS_TDATA_WIDTH, 8, data width in bits; multiple of 8.
- C_AXIS_TKEEP_WIDTH, 1, equals C_AXIS_TDATA_WIDTH/8.
- FRAME_LENGTH_WIDTH, 16, header width in bits; multiple of C_AXIS_TDATA_WIDTH; HDR_BEATS = FRAME_LENGTH_WIDTH/C_AXIS_TDATA_WIDTH (at least 1).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  combined stream data
- s_axis_tkeep  in  C_AXIS_TKEEP_WIDTH  byte enables; ignored on header beats
- s_axis_tvalid  in  1  valid
- s_axis_tready  out  1  ready
- s_axis_tlast  in  1  last beat of Ethernet frame
- m_axis_frame_length_tdata  out  C_AXIS_TDATA_WIDTH  header beat, LSB-first
- m_axis_frame_length_tvalid  out  1  valid
- m_axis_frame_length_tready  in  1  ready
- m_axis_frame_length_tlast  out  1  asserted on header beat HDR_BEATS-1
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  Ethernet payload
- m_axis_tkeep  out  C_AXIS_TKEEP_WIDTH  payload byte enables
- m_axis_tvalid  out  1  valid
- m_axis_tready  in  1  ready
- m_axis_tlast  out  1  last payload beat
- frame_error  out  1  one-cycle pulse on malformed frame / length mismatch

Behaviour:
- Reset (async, rstn=0): state=HDR, header counter=0, all output registers empty.
  - All m_*_tvalid=0, tdata/tkeep/tlast=0, frame_error=0, s_axis_tready=0.
  - Reset mid-frame discards partial frame and output-register contents; first beat after reset is treated as header beat 0.
- Each output is one register stage (valid/data/keep/last). The stage loads when empty or drained in the same cycle (tvalid&tready); a simultaneous drain and load keeps valid=1 with new data.
- Latency: input beat to output tvalid = 1 cycle; full throughput (1 beat/cycle) when downstream ready.
- s_axis_tready:
  - In HDR, equals frame-length stage empty-or-draining.
  - In PAYLOAD, equals payload stage empty-or-draining.
  - Registered-free combinational; no dependency on s_axis_tvalid.
- State machine:
  - HDR: each accepted beat goes to the frame-length stage, counter increments.
    - Counter==HDR_BEATS-1 with s_axis_tlast=0: set m_axis_frame_length_tlast=1, counter=0, go to PAYLOAD.
    - s_axis_tlast=1 on any header beat (truncated frame): forward beat with frame-length tlast=1, pulse frame_error, counter=0, stay in HDR. No payload output.
  - PAYLOAD: accepted beats go to the payload stage with tkeep/tlast copied. On s_axis_tlast, go to HDR.
- Header value is little-endian: beat 0 carries bits [C_AXIS_TDATA_WIDTH-1:0].
- Streams are independent once written: a stalled payload consumer does not block draining of the frame-length stage, and vice versa. The next header is blocked only if the frame-length stage is still full.
- Counter width is $clog2(HDR_BEATS) with a minimum of 1 bit; HDR_BEATS=1 gives a single-beat header.

Optional Feature:
- Macro SPLIT_FRAME_LENGTH_CHECK_EN.
- When defined:
  - Captures the header value into a FRAME_LENGTH_WIDTH register.
  - Sums popcount(s_axis_tkeep) over accepted payload beats in a FRAME_LENGTH_WIDTH saturating counter.
  - At payload tlast, compares the sum with the header value. On mismatch, pulses frame_error one cycle after the tlast beat is accepted.
  - Data is forwarded unchanged regardless of the result.
- When undefined: no capture or counter logic; frame_error pulses only on truncated header.

Test Plan:
- 8-bit, header 1518 (0xEE,0x05) + 1518-byte frame, all readies high: frame-length beats 0xEE, 0x05 (tlast on 2nd); 1518 payload beats, tlast on last; no bubbles; frame_error=0.
- Payload tready toggled 1/0 every 50 cycles, 3 back-to-back frames (64/1518/100 B): byte-exact payload, 3 frame-length pairs in order, no drop/duplication.
- Frame-length tready held low for 200 cycles after first header beat: s_axis_tready=0 while frame-length stage is full; resume yields correct 0x05 beat then payload.
- Truncated input: 1 header beat with tlast=1: one frame-length beat with tlast=1, frame_error pulse, no payload; next well-formed frame parsed correctly.
- rstn asserted asynchronously mid-payload (beat 300 of 1518): all valids drop immediately; after release, new 64-byte frame is split correctly.
- With SPLIT_FRAME_LENGTH_CHECK_EN, 32-bit data, header 61 + 64-byte frame: frame_error pulses once; header 64 + 64-byte frame: no pulse.

Source files
------------

// File: rtl/split_frame_length.sv
// -----------------------------------------------------------------------------
// split_frame_length
//   Splits a combined AXI4-Stream of the form [frame length header][Ethernet
//   frame] into a frame-length stream (header beats, LSB-first) and a payload
//   stream (Ethernet bytes with tkeep). Each output has one register stage, so
//   input-to-output latency is one cycle at full throughput. Once a beat is
//   written, the two streams drain independently of each other.
//
// Optional build macro:
//   SPLIT_FRAME_LENGTH_CHECK_EN - capture the header value, sum the accepted
//   payload bytes (popcount of tkeep, saturating) and pulse frame_error one
//   cycle after the payload tlast beat when the two differ. Data is forwarded
//   unchanged either way. Without the macro frame_error flags only truncated
//   headers.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   s_axis_*                        combined input stream (tdata/tkeep/tvalid/
//                                   tready/tlast); tkeep ignored on header beats
//   m_axis_frame_length_*           header beats, tlast on beat HDR_BEATS-1
//                                   (or on a truncated header beat)
//   m_axis_*                        Ethernet payload with tkeep/tlast
//   frame_error                     one-cycle pulse on truncated header or
//                                   (with the check enabled) length mismatch
// -----------------------------------------------------------------------------
module split_frame_length #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 8,
  parameter int unsigned C_AXIS_TKEEP_WIDTH = 1,
  parameter int unsigned FRAME_LENGTH_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,

  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,

  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_frame_length_tdata,
  output logic                          m_axis_frame_length_tvalid,
  input  logic                          m_axis_frame_length_tready,
  output logic                          m_axis_frame_length_tlast,

  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,

  output logic                          frame_error
);

  localparam int unsigned DW        = C_AXIS_TDATA_WIDTH;
  localparam int unsigned KW        = C_AXIS_TKEEP_WIDTH;
  localparam int unsigned FLW       = FRAME_LENGTH_WIDTH;
  localparam int unsigned HDR_BEATS = (FLW / DW) > 0 ? (FLW / DW) : 1;
  localparam int unsigned CNT_W     = HDR_BEATS > 1 ? $clog2(HDR_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HDR_BEATS - 1);

  typedef enum logic {
    ST_HDR,
    ST_PAYLOAD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hdr_cnt;

  // Output register stages
  logic           fl_valid;
  logic [DW-1:0]  fl_data;
  logic           fl_last;
  logic           pl_valid;
  logic [DW-1:0]  pl_data;
  logic [KW-1:0]  pl_keep;
  logic           pl_last;
  logic           err_q;

  // Handshake decode
  logic fl_free_c;
  logic pl_free_c;
  logic s_ready_c;
  logic hdr_accept_c;
  logic pl_accept_c;
  logic hdr_last_beat_c;
  logic truncated_c;
  logic mismatch_c;

  // Stage free when empty or draining this cycle; input ready follows the
  // stage the current state writes into. Held low while in reset.
  always_comb begin
    fl_free_c       = 1'b0;
    pl_free_c       = 1'b0;
    s_ready_c       = 1'b0;
    hdr_accept_c    = 1'b0;
    pl_accept_c     = 1'b0;
    hdr_last_beat_c = 1'b0;
    truncated_c     = 1'b0;

    fl_free_c = ~fl_valid | m_axis_frame_length_tready;
    pl_free_c = ~pl_valid | m_axis_tready;
    s_ready_c = rstn & ((state == ST_HDR) ? fl_free_c : pl_free_c);

    hdr_accept_c    = s_axis_tvalid & s_ready_c & (state == ST_HDR);
    pl_accept_c     = s_axis_tvalid & s_ready_c & (state == ST_PAYLOAD);
    hdr_last_beat_c = hdr_accept_c & (hdr_cnt == CNT_LAST);
    truncated_c     = hdr_accept_c & s_axis_tlast;
  end

  // Header / payload sequencing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_HDR;
      hdr_cnt <= '0;
    end else begin
      case (state)
        ST_HDR: begin
          if (hdr_accept_c) begin
            if (s_axis_tlast) begin
              hdr_cnt <= '0;
            end else if (hdr_cnt == CNT_LAST) begin
              hdr_cnt <= '0;
              state   <= ST_PAYLOAD;
            end else begin
              hdr_cnt <= hdr_cnt + CNT_W'(1);
            end
          end
        end
        ST_PAYLOAD: begin
          if (pl_accept_c && s_axis_tlast) begin
            state <= ST_HDR;
          end
        end
        default: begin
          state   <= ST_HDR;
          hdr_cnt <= '0;
        end
      endcase
    end
  end

  // Frame-length output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fl_valid <= 1'b0;
      fl_data  <= '0;
      fl_last  <= 1'b0;
    end else if (hdr_accept_c) begin
      fl_valid <= 1'b1;
      fl_data  <= s_axis_tdata;
      fl_last  <= hdr_last_beat_c | s_axis_tlast;
    end else if (m_axis_frame_length_tready) begin
      fl_valid <= 1'b0;
    end
  end

  // Payload output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pl_valid <= 1'b0;
      pl_data  <= '0;
      pl_keep  <= '0;
      pl_last  <= 1'b0;
    end else if (pl_accept_c) begin
      pl_valid <= 1'b1;
      pl_data  <= s_axis_tdata;
      pl_keep  <= s_axis_tkeep;
      pl_last  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      pl_valid <= 1'b0;
    end
  end

`ifdef SPLIT_FRAME_LENGTH_CHECK_EN
  localparam int unsigned SUM_W = FLW + 1;

  logic [FLW-1:0]   hdr_value;
  logic [FLW-1:0]   byte_sum;
  logic [SUM_W-1:0] sum_wide_c;
  logic [FLW-1:0]   sum_next_c;

  function automatic logic [SUM_W-1:0] popcount(input logic [KW-1:0] keep);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < KW; i++) begin
      n = n + SUM_W'(keep[i]);
    end
    return n;
  endfunction

  // Running byte count including the beat being accepted, saturating at max
  always_comb begin
    sum_wide_c = '0;
    sum_next_c = '0;
    mismatch_c = 1'b0;

    sum_wide_c = SUM_W'(byte_sum) + popcount(s_axis_tkeep);
    sum_next_c = sum_wide_c[FLW] ? {FLW{1'b1}} : sum_wide_c[FLW-1:0];
    mismatch_c = pl_accept_c & s_axis_tlast & (sum_next_c != hdr_value);
  end

  // Header capture (little-endian beat order) and payload byte accumulation
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr_value <= '0;
      byte_sum  <= '0;
    end else begin
      if (hdr_accept_c) begin
        for (int unsigned i = 0; i < HDR_BEATS; i++) begin
          if (hdr_cnt == CNT_W'(i)) begin
            hdr_value[i*DW +: DW] <= s_axis_tdata;
          end
        end
      end
      if (hdr_last_beat_c) begin
        byte_sum <= '0;
      end else if (pl_accept_c) begin
        byte_sum <= s_axis_tlast ? '0 : sum_next_c;
      end
    end
  end
`else
  always_comb begin
    mismatch_c = 1'b0;
  end
`endif

  // Error pulse, registered one cycle after the offending beat is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= truncated_c | mismatch_c;
    end
  end

  assign s_axis_tready              = s_ready_c;
  assign m_axis_frame_length_tdata  = fl_data;
  assign m_axis_frame_length_tvalid = fl_valid;
  assign m_axis_frame_length_tlast  = fl_last;
  assign m_axis_tdata               = pl_data;
  assign m_axis_tkeep               = pl_keep;
  assign m_axis_tvalid              = pl_valid;
  assign m_axis_tlast               = pl_last;
  assign frame_error                = err_q;

endmodule

// File: tb/tb_split_frame_length.sv
// -----------------------------------------------------------------------------
// tb_split_frame_length
//   Bench for split_frame_length. dut: 8-bit data, 16-bit header (2 beats).
//   dut2: 32-bit data, 32-bit header (1 beat), used for the length check.
//   Expected streams come from a queue model built from the frame contents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_split_frame_length;

`ifdef SPLIT_FRAME_LENGTH_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;

  logic [7:0] s_tdata;
  logic [0:0] s_tkeep;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic [7:0] fl_tdata;
  logic       fl_tvalid;
  logic       fl_tready;
  logic       fl_tlast;
  logic [7:0] m_tdata;
  logic [0:0] m_tkeep;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       frame_error;

  logic [31:0] s2_tdata;
  logic [3:0]  s2_tkeep;
  logic        s2_tvalid;
  logic        s2_tready;
  logic        s2_tlast;
  logic [31:0] f2_tdata;
  logic        f2_tvalid;
  logic        f2_tlast;
  logic [31:0] p2_tdata;
  logic [3:0]  p2_tkeep;
  logic        p2_tvalid;
  logic        p2_tlast;
  logic        err2;

  split_frame_length #(
    .C_AXIS_TDATA_WIDTH(8), .C_AXIS_TKEEP_WIDTH(1), .FRAME_LENGTH_WIDTH(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_frame_length_tdata(fl_tdata), .m_axis_frame_length_tvalid(fl_tvalid),
    .m_axis_frame_length_tready(fl_tready), .m_axis_frame_length_tlast(fl_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .frame_error(frame_error)
  );

  split_frame_length #(
    .C_AXIS_TDATA_WIDTH(32), .C_AXIS_TKEEP_WIDTH(4), .FRAME_LENGTH_WIDTH(32)
  ) dut2 (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s2_tdata), .s_axis_tkeep(s2_tkeep), .s_axis_tvalid(s2_tvalid),
    .s_axis_tready(s2_tready), .s_axis_tlast(s2_tlast),
    .m_axis_frame_length_tdata(f2_tdata), .m_axis_frame_length_tvalid(f2_tvalid),
    .m_axis_frame_length_tready(1'b1), .m_axis_frame_length_tlast(f2_tlast),
    .m_axis_tdata(p2_tdata), .m_axis_tkeep(p2_tkeep), .m_axis_tvalid(p2_tvalid),
    .m_axis_tready(1'b1), .m_axis_tlast(p2_tlast),
    .frame_error(err2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model queues: expected vs observed beats
  logic [8:0] fl_exp[$];
  logic [8:0] fl_got[$];
  logic [9:0] pl_exp[$];
  logic [9:0] pl_got[$];
  int         pl_cyc[$];
  int         err_cnt = 0;

  int          f2_cnt = 0;
  logic [32:0] f2_last_beat;
  int          p2_beats = 0;
  int          err2_cnt = 0;

  int pl_mode = 0;   // 0: always ready, 1: toggle every 50 cycles
  bit fl_hold = 0;
  bit abort   = 0;
  bit busy    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready generation
  always @(posedge clk) begin
    #1;
    m_tready  = (pl_mode == 0) ? 1'b1 : (((cyc / 50) % 2) == 0);
    fl_tready = !fl_hold;
  end

  // Output monitors; inputs change #1 after posedge, so a handshake seen at
  // negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rstn) begin
      if (fl_tvalid && fl_tready) fl_got.push_back({fl_tlast, fl_tdata});
      if (m_tvalid && m_tready) begin
        pl_got.push_back({m_tkeep, m_tlast, m_tdata});
        pl_cyc.push_back(cyc);
      end
      if (frame_error) err_cnt++;
      if (f2_tvalid) begin
        f2_cnt++;
        f2_last_beat = {f2_tlast, f2_tdata};
      end
      if (p2_tvalid) p2_beats++;
      if (err2) err2_cnt++;
    end
  end

  function automatic int diff_fl();
    int bad = 0;
    int n   = (fl_got.size() < fl_exp.size()) ? fl_got.size() : fl_exp.size();
    bad = (fl_got.size() > fl_exp.size()) ? fl_got.size() - fl_exp.size()
                                          : fl_exp.size() - fl_got.size();
    for (int i = 0; i < n; i++) if (fl_got[i] !== fl_exp[i]) bad++;
    return bad;
  endfunction

  function automatic int diff_pl();
    int bad = 0;
    int n   = (pl_got.size() < pl_exp.size()) ? pl_got.size() : pl_exp.size();
    bad = (pl_got.size() > pl_exp.size()) ? pl_got.size() - pl_exp.size()
                                          : pl_exp.size() - pl_got.size();
    for (int i = 0; i < n; i++) if (pl_got[i] !== pl_exp[i]) bad++;
    return bad;
  endfunction

  task automatic clear_model();
    fl_exp.delete(); fl_got.delete();
    pl_exp.delete(); pl_got.delete(); pl_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, output bit ok);
    int t = 0;
    ok = 1'b1;
    s_tdata = d; s_tlast = last; s_tkeep = 1'b1; s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (abort) begin ok = 1'b0; break; end
      if (s_tready) break;
      t++;
      if (t > 5000) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: s_axis_tready stayed %0b, required 1 within 5000 cycles", s_tready);
        abort = 1'b1; ok = 1'b0;
        break;
      end
    end
    if (ok) begin @(posedge clk); #1; end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // Header (len, LSB byte first) followed by nbytes random payload bytes
  task automatic send_frame(input int len, input int nbytes);
    bit ok;
    logic [7:0] b;
    busy = 1'b1;
    fl_exp.push_back({1'b0, len[7:0]});
    fl_exp.push_back({1'b1, len[15:8]});
    send_beat(len[7:0], 1'b0, ok);
    if (ok) send_beat(len[15:8], 1'b0, ok);
    for (int i = 0; i < nbytes && ok; i++) begin
      b = 8'($urandom);
      pl_exp.push_back({1'b1, (i == nbytes - 1), b});
      send_beat(b, (i == nbytes - 1), ok);
    end
    busy = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((busy || fl_got.size() < fl_exp.size() || pl_got.size() < pl_exp.size()) && t < 20000) begin
      @(negedge clk); t++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s2_tdata = '0; s2_tkeep = '0; s2_tvalid = 1'b0; s2_tlast = 1'b0;
    m_tready = 1'b1; fl_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (fl_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_fl_tvalid: got %b want 0", fl_tvalid); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
    n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    n_cmp++; if ({fl_tdata, fl_tlast, m_tdata, m_tkeep, m_tlast} !== 19'd0) begin
      n_bad++; $display("FAIL reset_data: got fl=%h m=%h keep=%b want zeros", fl_tdata, m_tdata, m_tkeep);
    end
    @(posedge clk); #1; rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL idle_s_tready: got %b want 1", s_tready); end
  endtask

  task automatic test_full_frame();
    int d;
    clear_model(); pl_mode = 0;
    @(posedge clk); #1;
    send_frame(1518, 1518);
    wait_drain();
    n_cmp++; if (fl_got.size() != 2 || fl_got[0] !== 9'h0EE || fl_got[1] !== 9'h105) begin
      n_bad++; $display("FAIL full_fl_beats: got %0d beats (%h %h) want 0ee 105", fl_got.size(),
                        fl_got.size() > 0 ? fl_got[0] : 9'h0, fl_got.size() > 1 ? fl_got[1] : 9'h0);
    end
    d = diff_pl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL full_payload: %0d bad beats of %0d got, want 0 bad of 1518", d, pl_got.size()); end
    n_cmp++; if (pl_cyc.size() != 1518 || pl_cyc[pl_cyc.size()-1] - pl_cyc[0] != 1517) begin
      n_bad++; $display("FAIL full_no_bubbles: payload span %0d cycles over %0d beats, want 1517 over 1518",
                        pl_cyc.size() > 0 ? pl_cyc[pl_cyc.size()-1] - pl_cyc[0] : -1, pl_cyc.size());
    end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL full_frame_error: got %0d pulses want 0", err_cnt); end
  endtask

  task automatic test_back_to_back();
    int d;
    clear_model(); pl_mode = 1;
    @(posedge clk); #1;
    send_frame(64, 64);
    send_frame(1518, 1518);
    send_frame(100, 100);
    wait_drain();
    pl_mode = 0;
    d = diff_fl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL b2b_fl: %0d bad of %0d beats, want 0 of 6", d, fl_got.size()); end
    d = diff_pl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL b2b_payload: %0d bad of %0d beats, want 0 of 1682", d, pl_got.size()); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL b2b_frame_error: got %0d pulses want 0", err_cnt); end
  endtask

  task automatic test_fl_stall();
    int t = 0;
    int viol = 0;
    int d;
    clear_model(); pl_mode = 0; fl_hold = 1'b1;
    repeat (2) @(posedge clk); #1;
    fork send_frame(1518, 1518); join_none
    while (!fl_tvalid && t < 50) begin @(negedge clk); t++; end
    n_cmp++; if (fl_tvalid !== 1'b1 || fl_tdata !== 8'hEE) begin
      n_bad++; $display("FAIL stall_first_beat: got valid=%b data=%h want 1 ee", fl_tvalid, fl_tdata);
    end
    repeat (200) begin
      @(negedge clk);
      if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || fl_tvalid !== 1'b1) viol++;
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL stall_hold: %0d cycles with ready/valid wrong, want 0", viol); end
    @(posedge clk); #1; fl_hold = 1'b0;
    wait_drain();
    d = diff_fl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL stall_fl: %0d bad of %0d beats, want 0 of 2", d, fl_got.size()); end
    d = diff_pl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL stall_payload: %0d bad of %0d beats, want 0 of 1518", d, pl_got.size()); end
  endtask

  task automatic test_truncated();
    bit ok;
    int d;
    clear_model(); pl_mode = 0;
    @(posedge clk); #1;
    fl_exp.push_back({1'b1, 8'h3C});
    send_beat(8'h3C, 1'b1, ok);
    repeat (4) @(negedge clk);
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL trunc_frame_error: got %0d pulses want 1", err_cnt); end
    n_cmp++; if (pl_got.size() != 0) begin n_bad++; $display("FAIL trunc_no_payload: got %0d beats want 0", pl_got.size()); end
    @(posedge clk); #1;
    send_frame(64, 64);
    wait_drain();
    d = diff_fl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL trunc_fl: %0d bad of %0d beats, want 0 of 3", d, fl_got.size()); end
    d = diff_pl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL trunc_payload: %0d bad of %0d beats, want 0 of 64", d, pl_got.size()); end
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL trunc_recover_error: got %0d pulses want 1", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int d;
    clear_model(); pl_mode = 0;
    @(posedge clk); #1;
    fork send_frame(1518, 1518); join_none
    while (pl_got.size() < 300 && t < 1000) begin @(negedge clk); t++; end
    @(posedge clk); #3;
    n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", m_tvalid); end
    rstn = 1'b0; abort = 1'b1;
    #1;
    n_cmp++; if ({fl_tvalid, m_tvalid, s_tready} !== 3'b000) begin
      n_bad++; $display("FAIL midrst_valids: got fl=%b m=%b rdy=%b want 000", fl_tvalid, m_tvalid, s_tready);
    end
    t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    rstn = 1'b1; abort = 1'b0;
    clear_model();
    @(posedge clk); #1;
    send_frame(64, 64);
    wait_drain();
    d = diff_fl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL midrst_fl: %0d bad of %0d beats, want 0 of 2", d, fl_got.size()); end
    d = diff_pl();
    n_cmp++; if (d != 0) begin n_bad++; $display("FAIL midrst_payload: %0d bad of %0d beats, want 0 of 64", d, pl_got.size()); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL midrst_frame_error: got %0d pulses want 0", err_cnt); end
  endtask

  // 32-bit instance: one header beat carrying hdr, then nbytes payload bytes
  task automatic send2(input int hdr, input int nbytes);
    int nbeats = (nbytes + 3) / 4;
    int t;
    for (int i = -1; i < nbeats; i++) begin
      s2_tvalid = 1'b1;
      if (i < 0) begin
        s2_tdata = 32'(hdr); s2_tkeep = 4'hF; s2_tlast = 1'b0;
      end else begin
        s2_tdata = $urandom;
        s2_tlast = (i == nbeats - 1);
        s2_tkeep = (i == nbeats - 1 && (nbytes % 4) != 0) ? 4'((1 << (nbytes % 4)) - 1) : 4'hF;
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!s2_tready && t < 100);
      @(posedge clk); #1;
    end
    s2_tvalid = 1'b0; s2_tlast = 1'b0;
  endtask

  task automatic test_length_check();
    int hdrs[4]  = '{61, 64, 62, 64};
    int bytes[4] = '{64, 64, 62, 62};
    int exp_err;
    for (int k = 0; k < 4; k++) begin
      f2_cnt = 0; p2_beats = 0; err2_cnt = 0;
      @(posedge clk); #1;
      send2(hdrs[k], bytes[k]);
      repeat (5) @(negedge clk);
      exp_err = (CHECK_EN && hdrs[k] != bytes[k]) ? 1 : 0;
      n_cmp++; if (err2_cnt != exp_err) begin
        n_bad++; $display("FAIL check_err_%0d: got %0d pulses want %0d (hdr %0d, %0d bytes)", k, err2_cnt, exp_err, hdrs[k], bytes[k]);
      end
      n_cmp++; if (p2_beats != (bytes[k] + 3) / 4) begin
        n_bad++; $display("FAIL check_beats_%0d: got %0d want %0d", k, p2_beats, (bytes[k] + 3) / 4);
      end
      n_cmp++; if (f2_cnt != 1 || f2_last_beat !== {1'b1, 32'(hdrs[k])}) begin
        n_bad++; $display("FAIL check_hdr_%0d: got %0d beats last=%h want 1 beat %h", k, f2_cnt, f2_last_beat, {1'b1, 32'(hdrs[k])});
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_fl_stall();
    test_truncated();
    test_reset_mid();
    test_length_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
